// File: rtl/data_mem_access.sv
// Purpose: MEM-stage data memory with byte/half/word access, sign/zero-extended loads, fault detection.
// Latency: request seen in IDLE (C0), access at end of C(LATENCY), results valid in DONE (C(LATENCY+1)).
// Backpressure: Busy stalls upstream from C0 through C(LATENCY); request inputs must stay stable meanwhile.
module data_mem_access #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        Mem_Read,
    input  logic        Mem_Write,
    input  logic [2:0]  Funct3,
    input  logic [31:0] Address,
    input  logic [31:0] Write_Data,
    output logic [31:0] Memory_Data,
    output logic        Busy,
    output logic        Access_Fault
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [AW+1:0] addr_q;
    logic [31:0]   wdat_q;
    logic [2:0]    f3_q;
    logic          store_q;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          req;
    logic [AW-1:0] widx;
    logic [1:0]    boff;
    logic [31:0]   rd_word;
    logic          fault;
    logic [3:0]    be;
    logic [31:0]   wr_rep;
    logic [31:0]   wr_word;
    logic [7:0]    sel_byte;
    logic [15:0]   sel_half;
    logic [31:0]   ld_val;
    logic          access;
    logic          do_write;
    logic          unused_addr_hi;

    // Address bits above the memory size alias; they are deliberately dropped.
    assign unused_addr_hi = ^Address[31:AW+2];

    // A store wins when both read and write are asserted.
    assign req     = Mem_Read | Mem_Write;
    assign widx    = addr_q[AW+1:2];
    assign boff    = addr_q[1:0];
    assign rd_word = mem[widx];
    assign access  = (state == S_WAIT) && (cnt == '0);
    assign do_write = access && store_q && !fault && Reset;

    // Stall while a request is being accepted or in flight; never during DONE or reset.
    always_comb begin
        Busy = Reset && (((state == S_IDLE) && req) || (state == S_WAIT));
    end

    // Decode the captured access into a fault flag, byte enables and lane-replicated store data.
    always_comb begin
        fault  = 1'b0;
        be     = 4'b0000;
        wr_rep = wdat_q;
        if (store_q) begin
            case (f3_q)
                3'b000: begin
                    be     = 4'b0001 << boff;
                    wr_rep = {4{wdat_q[7:0]}};
                end
                3'b001: begin
                    fault  = boff[0];
                    be     = boff[1] ? 4'b1100 : 4'b0011;
                    wr_rep = {2{wdat_q[15:0]}};
                end
                3'b010: begin
                    fault = |boff;
                    be    = 4'b1111;
                end
                default: fault = 1'b1;
            endcase
        end else begin
            case (f3_q)
                3'b000, 3'b100: fault = 1'b0;
                3'b001, 3'b101: fault = boff[0];
                3'b010:         fault = |boff;
                default:        fault = 1'b1;
            endcase
        end
        if (fault) begin
            be = 4'b0000;
        end
    end

    // Merge enabled store lanes into the current word (read-modify-write of one word).
    always_comb begin
        wr_word = rd_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                wr_word[8*i +: 8] = wr_rep[8*i +: 8];
            end
        end
    end

    // Select the addressed lane and extend it; Funct3[2] marks the unsigned variants.
    always_comb begin
        case (boff)
            2'd0:    sel_byte = rd_word[7:0];
            2'd1:    sel_byte = rd_word[15:8];
            2'd2:    sel_byte = rd_word[23:16];
            default: sel_byte = rd_word[31:24];
        endcase
        sel_half = boff[1] ? rd_word[31:16] : rd_word[15:0];
        case (f3_q[1:0])
            2'b00:   ld_val = {{24{sel_byte[7] & ~f3_q[2]}}, sel_byte};
            2'b01:   ld_val = {{16{sel_half[15] & ~f3_q[2]}}, sel_half};
            default: ld_val = rd_word;
        endcase
    end

    // Memory array: no reset, contents survive Reset.
    always_ff @(posedge CLK) begin
        if (do_write) begin
            mem[widx] <= wr_word;
        end
    end

    // Access sequencer: IDLE captures, WAIT counts down then performs the access, DONE presents results.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            addr_q       <= '0;
            wdat_q       <= '0;
            f3_q         <= '0;
            store_q      <= 1'b0;
            Memory_Data  <= '0;
            Access_Fault <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        addr_q  <= Address[AW+1:0];
                        wdat_q  <= Write_Data;
                        f3_q    <= Funct3;
                        store_q <= Mem_Write;
                        cnt     <= CNT_INIT;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        if (fault) begin
                            Memory_Data  <= '0;
                            Access_Fault <= 1'b1;
                        end else if (!store_q) begin
                            Memory_Data <= ld_val;
                        end
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    Access_Fault <= 1'b0;
                    state        <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_access.sv
// Bench for data_mem_access: directed test-plan sequence followed by randomized loads/stores.
// A transaction-level model predicts Busy/Memory_Data/Access_Fault for every cycle.
// Outputs are compared on each falling edge; inputs change 1 ns after the rising edge.
module tb_data_mem_access;

    localparam int DEPTH = 256;
    localparam int LAT   = 2;

    logic        CLK        = 1'b0;
    logic        Reset      = 1'b0;
    logic        Mem_Read   = 1'b1;
    logic        Mem_Write  = 1'b0;
    logic [2:0]  Funct3     = 3'b011;
    logic [31:0] Address    = 32'h0;
    logic [31:0] Write_Data = 32'h0;
    logic [31:0] Memory_Data;
    logic        Busy;
    logic        Access_Fault;

    data_mem_access #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .Mem_Read     (Mem_Read),
        .Mem_Write    (Mem_Write),
        .Funct3       (Funct3),
        .Address      (Address),
        .Write_Data   (Write_Data),
        .Memory_Data  (Memory_Data),
        .Busy         (Busy),
        .Access_Fault (Access_Fault)
    );

    always #5 CLK = ~CLK;

    int          n_chk  = 0;
    int          n_pass = 0;
    bit          run    = 1'b1;
    logic        exp_busy = 1'b0;
    logic [31:0] exp_md   = 32'h0;
    logic        exp_af   = 1'b0;
    // Model memory: the bench only touches the first 16 words (address bits [9:6] kept zero).
    logic [31:0] mm [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    endtask

    // Per-cycle comparison against the model's expectations.
    always @(negedge CLK) begin
        if (run) begin
            chk("busy", {31'b0, Busy}, {31'b0, exp_busy});
            chk("memory_data", Memory_Data, exp_md);
            chk("access_fault", {31'b0, Access_Fault}, {31'b0, exp_af});
        end
    end

    function automatic bit fault_of(input bit st, input logic [2:0] f3, input logic [31:0] a);
        if (st) begin
            if (f3 == 3'd0) return 1'b0;
            if (f3 == 3'd1) return a[0];
            if (f3 == 3'd2) return a[1:0] != 2'b00;
            return 1'b1;
        end
        if (f3 == 3'd0 || f3 == 3'd4) return 1'b0;
        if (f3 == 3'd1 || f3 == 3'd5) return a[0];
        if (f3 == 3'd2) return a[1:0] != 2'b00;
        return 1'b1;
    endfunction

    function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] w;
        logic [31:0] b;
        logic [31:0] h;
        w = mm[a[5:2]];
        b = (w >> (8 * a[1:0])) & 32'hFF;
        h = (w >> (16 * a[1])) & 32'hFFFF;
        case (f3)
            3'd0:    return (b ^ 32'h80) - 32'h80;
            3'd4:    return b;
            3'd1:    return (h ^ 32'h8000) - 32'h8000;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    task automatic store_apply(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        case (f3)
            3'd0:    mm[a[5:2]][8 * a[1:0] +: 8] = wd[7:0];
            3'd1:    mm[a[5:2]][16 * a[1] +: 16] = wd[15:0];
            default: mm[a[5:2]] = wd;
        endcase
    endtask

    // Advance into the next cycle; default expectation is an idle, non-DONE cycle.
    task automatic step();
        @(posedge CLK);
        #1;
        exp_busy = 1'b0;
        exp_af   = 1'b0;
    endtask

    // One transaction (or an idle cycle when neither request is set). Returns in the DONE cycle.
    task automatic do_req(input bit rd, input bit wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd);
        bit          flt;
        logic [31:0] v;
        step();
        Reset      = 1'b1;
        Mem_Read   = rd;
        Mem_Write  = wr;
        Funct3     = f3;
        Address    = a;
        Write_Data = wd;
        if (rd || wr) begin
            flt = fault_of(wr, f3, a);
            v   = (!wr && !flt) ? load_val(f3, a) : 32'h0;
            exp_busy = 1'b1;
            repeat (LAT) begin
                step();
                exp_busy = 1'b1;
            end
            step();
            if (flt) begin
                exp_md = 32'h0;
                exp_af = 1'b1;
            end else if (wr) begin
                store_apply(f3, a, wd);
            end else begin
                exp_md = v;
            end
        end
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] a;
        int          k;

        // Reset held with a load request pending: everything quiet.
        #3;
        chk("rst_busy", {31'b0, Busy}, 32'h0);
        chk("rst_md", Memory_Data, 32'h0);
        chk("rst_af", {31'b0, Access_Fault}, 32'h0);
        // Release reset with the request present (undefined load code -> fault).
        do_req(1'b1, 1'b0, 3'b011, 32'h0, 32'h0);
        chk("undef_load_af", {31'b0, Access_Fault}, 32'h1);

        // SW then LW.
        do_req(1'b0, 1'b1, 3'd2, 32'h10, 32'hA5A5A5A5);
        do_req(1'b1, 1'b0, 3'd2, 32'h10, 32'h0);
        chk("lw_0x10", Memory_Data, 32'hA5A5A5A5);
        chk("lw_done_busy", {31'b0, Busy}, 32'h0);

        // Byte lanes.
        do_req(1'b0, 1'b1, 3'd2, 32'h20, 32'h0);
        do_req(1'b0, 1'b1, 3'd0, 32'h21, 32'h12345680);
        do_req(1'b1, 1'b0, 3'd2, 32'h20, 32'h0);
        chk("lw_0x20", Memory_Data, 32'h00008000);
        do_req(1'b1, 1'b0, 3'd0, 32'h21, 32'h0);
        chk("lb_0x21", Memory_Data, 32'hFFFFFF80);
        do_req(1'b1, 1'b0, 3'd4, 32'h21, 32'h0);
        chk("lbu_0x21", Memory_Data, 32'h00000080);
        do_req(1'b1, 1'b0, 3'd1, 32'h20, 32'h0);
        chk("lh_0x20", Memory_Data, 32'hFFFF8000);
        chk("model_lh", exp_md, 32'hFFFF8000);

        // Misaligned store must fault and leave memory alone.
        do_req(1'b0, 1'b1, 3'd1, 32'h23, 32'hFFFFFFFF);
        chk("sh_mis_af", {31'b0, Access_Fault}, 32'h1);
        chk("sh_mis_md", Memory_Data, 32'h0);
        do_req(1'b1, 1'b0, 3'd2, 32'h20, 32'h0);
        chk("lw_after_mis", Memory_Data, 32'h00008000);

        // Reset pulsed while the store is waiting: store abandoned.
        do_req(1'b0, 1'b1, 3'd2, 32'h30, 32'h0);
        step();
        Mem_Read = 1'b0; Mem_Write = 1'b1; Funct3 = 3'd2;
        Address = 32'h30; Write_Data = 32'h12345678;
        exp_busy = 1'b1;
        step();
        exp_busy = 1'b1;
        #2;
        Reset = 1'b0;
        exp_busy = 1'b0; exp_md = 32'h0; exp_af = 1'b0;
        step();
        Reset = 1'b1;
        Mem_Write = 1'b0;
        do_req(1'b1, 1'b0, 3'd2, 32'h30, 32'h0);
        chk("lw_after_rst", Memory_Data, 32'h0);

        // Wrap: 0x404 aliases word 1.
        do_req(1'b0, 1'b1, 3'd2, 32'h404, 32'hDEADBEEF);
        do_req(1'b1, 1'b0, 3'd2, 32'h004, 32'h0);
        chk("lw_wrap", Memory_Data, 32'hDEADBEEF);

        // Give all 16 modelled words known contents, via aliased addresses.
        for (int i = 0; i < 16; i++) begin
            r = $urandom();
            do_req(1'b0, 1'b1, 3'd2, (r & 32'hFFFF_FC00) | (i * 4), $urandom());
        end

        // Randomized traffic, including idle gaps, back-to-back requests and faults.
        for (int n = 0; n < 400; n++) begin
            k = $urandom_range(0, 9);
            a = $urandom() & 32'hFFFF_FC3F;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            r = $urandom();
            if (k < 2)      do_req(1'b0, 1'b0, 3'(r[2:0]), a, r);
            else if (k < 6) do_req(1'b1, 1'b0, 3'($urandom_range(0, 7)), a, r);
            else if (k < 9) do_req(1'b0, 1'b1, 3'($urandom_range(0, 3)), a, r);
            else            do_req(1'b1, 1'b1, 3'($urandom_range(0, 2)), a, r);
        end

        step();
        Mem_Read = 1'b0; Mem_Write = 1'b0;
        step();
        run = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
